// File: rtl/mem_param_clr.sv
// Register-based RAM with write-first read bypass and a full-memory clear sweep.
// A clear request walks a counter over every word, one per clock, while busy is high.
module mem_param_clr #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              clr_req,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  // A clear request wins over a same-edge write; reads are served either way.
  assign wr_en   = (state == IDLE) && we && !clr_req;
  assign rd_en   = (state == IDLE) && re;
  assign rd_word = (wr_en && (waddr == raddr)) ? wdata : mem[raddr];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + (ADDR_W + 1)'(1);
        if (cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy   <= (state_nxt == CLEAR);
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_word;
      if (state == CLEAR) mem[cnt[ADDR_W-1:0]] <= '0;
      else if (wr_en)     mem[waddr] <= wdata;
    end
  end

endmodule

// File: tb/tb_mem_param_clr.sv
// Bench for mem_param_clr: directed vector table, clear/reset corner sequences,
// random traffic against a behavioural model, and a wide/deep parameter instance.
module tb_mem_param_clr;

  logic       clk = 1'b0;
  logic       rst_n, we, re, clr_req;
  logic [3:0] waddr, raddr;
  logic [7:0] wdata, rdata;
  logic       rvalid, busy;

  logic        b_rst_n, b_we, b_re, b_clr_req;
  logic [5:0]  b_waddr, b_raddr;
  logic [15:0] b_wdata, b_rdata;
  logic        b_rvalid, b_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_param_clr dut (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .clr_req(clr_req),
    .rdata(rdata), .rvalid(rvalid), .busy(busy)
  );

  mem_param_clr #(.DATA_W(16), .ADDR_W(6)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .clr_req(b_clr_req),
    .rdata(b_rdata), .rvalid(b_rvalid), .busy(b_busy)
  );

  // Behavioural model: memory array plus number of sweep cycles still owed.
  logic [7:0] m_mem [16];
  logic [7:0] m_rdata;
  logic       m_rvalid;
  int         m_left;

  typedef struct {
    logic       rst_n, we, re, clr;
    logic [3:0] waddr, raddr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_rvalid, exp_busy;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r_n, input logic w, input logic [3:0] wa,
                            input logic [7:0] wd, input logic r, input logic [3:0] ra,
                            input logic c);
    if (!r_n) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
      m_rdata = 8'h00; m_rvalid = 1'b0; m_left = 0;
    end else if (m_left > 0) begin
      m_mem[16 - m_left] = 8'h00;
      m_left--;
      m_rvalid = 1'b0;
    end else begin
      m_rvalid = r;
      if (r) m_rdata = (w && !c && wa == ra) ? wd : m_mem[ra];
      if (w && !c) m_mem[wa] = wd;
      if (c) m_left = 16;
    end
  endtask

  task automatic cyc(input logic r_n, input logic w, input logic [3:0] wa,
                     input logic [7:0] wd, input logic r, input logic [3:0] ra,
                     input logic c);
    rst_n = r_n; we = w; waddr = wa; wdata = wd; re = r; raddr = ra; clr_req = c;
    @(posedge clk);
    model_edge(r_n, w, wa, wd, r, ra, c);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_rvalid"}, 32'(rvalid), 32'(m_rvalid));
    check({tag, "_busy"}, 32'(busy), 32'(m_left > 0));
    check({tag, "_rdata"}, 32'(rdata), 32'(m_rdata));
  endtask

  task automatic cyc_b(input logic r_n, input logic w, input logic [5:0] wa,
                       input logic [15:0] wd, input logic r, input logic [5:0] ra,
                       input logic c);
    b_rst_n = r_n; b_we = w; b_waddr = wa; b_wdata = wd;
    b_re = r; b_raddr = ra; b_clr_req = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    b_rst_n = 1'b0; b_we = 0; b_re = 0; b_clr_req = 0;
    b_waddr = '0; b_raddr = '0; b_wdata = '0;

    // rst, we, re, clr, waddr, raddr, wdata, exp_rdata, exp_rvalid, exp_busy
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 8'h99, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 8'hA5, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd3, 8'h00, 8'hA5, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'hA5, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd0, 8'h11, 8'hA5, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd7, 8'h3C, 8'h3C, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 8'h00, 8'h3C, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd5, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd3, 8'h22, 8'hA5, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 8'h00, 8'h22, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 8'h00, 8'h22, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      cyc(tbl[i].rst_n, tbl[i].we, tbl[i].waddr, tbl[i].wdata, tbl[i].re,
          tbl[i].raddr, tbl[i].clr);
      check($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(tbl[i].exp_rdata));
      check($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].exp_rvalid));
      check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Fill with 0xFF, clear, and hammer we/re during the sweep.
    for (int a = 0; a < 16; a++) cyc(1, 1, 4'(a), 8'hFF, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    check_model("clr_start");
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      cyc(1, 1, 4'($urandom_range(15)), 8'hEE, 1, 4'($urandom_range(15)), 1);
      check_model("sweep");
    end
    check("busy_cycles16", 32'(cnt), 32'd16);
    for (int a = 0; a < 16; a++) begin
      cyc(1, 0, 0, 0, 1, 4'(a), 0);
      check($sformatf("post_clr_rd%0d", a), 32'(rdata), 32'h00);
    end

    // clr_req together with a write and a read.
    cyc(1, 1, 4'd2, 8'h22, 0, 0, 0);
    cyc(1, 1, 4'd0, 8'h55, 1, 4'd2, 1);
    check("clr_rd_data", 32'(rdata), 32'h22);
    check("clr_rd_valid", 32'(rvalid), 32'd1);
    check("clr_rd_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 16; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    check("clr_rd_busy_done", 32'(busy), 32'd0);
    cyc(1, 0, 0, 0, 1, 4'd0, 0);
    check("clr_dropped_wr", 32'(rdata), 32'h00);

    // Reset in the middle of a sweep.
    for (int a = 0; a < 16; a++) cyc(1, 1, 4'(a), 8'(8'h80 + a), 0, 0, 0);
    cyc(1, 0, 0, 0, 1, 4'd9, 0);
    cyc(1, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 0, 0, 0, 0, 0, 0);
    check("mid_busy_pre", 32'(busy), 32'd1);
    cyc(0, 1, 4'd1, 8'h77, 1, 4'd12, 1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_rdata", 32'(rdata), 32'h00);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    for (int a = 0; a < 16; a++) begin
      cyc(1, 0, 0, 0, 1, 4'(a), 0);
      check($sformatf("mid_rst_rd%0d", a), 32'(rdata), 32'h00);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(99) != 0), 1'($urandom), 4'($urandom), 8'($urandom),
          1'($urandom), 4'($urandom), ($urandom_range(24) == 0));
      check_model($sformatf("rnd%0d", k));
    end

    // Wider/deeper instance.
    cyc_b(0, 0, 0, 0, 0, 0, 0);
    cyc_b(1, 1, 6'd63, 16'hBEEF, 0, 0, 0);
    cyc_b(1, 0, 0, 0, 1, 6'd63, 0);
    check("b_rd63", 32'(b_rdata), 32'hBEEF);
    check("b_rv63", 32'(b_rvalid), 32'd1);
    cyc_b(1, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    while (b_busy && cnt < 100) begin
      cnt++;
      cyc_b(1, 0, 0, 0, 0, 0, 0);
    end
    check("b_busy_cycles64", 32'(cnt), 32'd64);
    cyc_b(1, 0, 0, 0, 1, 6'd63, 0);
    check("b_rd63_cleared", 32'(b_rdata), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_param_clr.md
MEM_PARAM_CLR -- requirements
Module: mem_param_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; depth DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port we  input  1  write enable.
REQ-006 The block SHALL have port waddr  input  ADDR_W  write address.
REQ-007 The block SHALL have port wdata  input  DATA_W  write data.
REQ-008 The block SHALL have port re  input  1  read enable.
REQ-009 The block SHALL have port raddr  input  ADDR_W  read address.
REQ-010 The block SHALL have port clr_req  input  1  request a full-memory clear sweep.
REQ-011 The block SHALL have port rdata  output  DATA_W  registered read data.
REQ-012 The block SHALL have port rvalid  output  1  one-cycle pulse marking new rdata.
REQ-013 The block SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-014 The block SHALL contain DEPTH x DATA_W storage with two states: IDLE and CLEAR.
REQ-015 In IDLE, a rising edge with we=1 SHALL write wdata to mem[waddr].
REQ-016 In IDLE, a rising edge with re=1 SHALL load rdata with mem[raddr] and set rvalid=1 for exactly one cycle; read latency 1 cycle.
REQ-017 When re=0, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-018 Simultaneous we=1, re=1 and waddr==raddr SHALL return wdata on rdata (write-first bypass) and update memory.
REQ-019 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-020 In IDLE, a rising edge with clr_req=1 SHALL move to CLEAR with sweep counter = 0 and busy=1 from the next cycle.
REQ-021 clr_req and we in the same IDLE edge SHALL drop the write; a read in that edge SHALL still be served.
REQ-022 In CLEAR, each rising edge SHALL write all-zero to mem[counter] and increment the counter by 1.
REQ-023 The edge that clears address DEPTH-1 SHALL return the state to IDLE and deassert busy; busy is therefore high for exactly DEPTH cycles.
REQ-024 In CLEAR, we, re and clr_req SHALL be ignored: no write, rvalid=0, rdata held, no sweep restart.
REQ-025 The sweep counter SHALL be ADDR_W+1 bits or equivalent, so no wrap-around occurs before termination.
REQ-026 busy SHALL be a registered output, glitch-free, with no combinational path from any input.

Reset
REQ-027 At a rising edge with rst_n=0, all memory words, rdata, rvalid, busy and the sweep counter SHALL become 0 and the state SHALL become IDLE.
REQ-028 Reset SHALL override all other inputs at that edge, including we, re and clr_req.
REQ-029 Reset asserted mid-sweep SHALL abort the sweep and clear all memory in that single edge.
REQ-030 Reset SHALL have no effect between clock edges.

Verification
REQ-031 Defaults; write 0xA5 at address 3, then re at address 3 -> rdata=0xA5 and rvalid=1 one cycle after the read edge, then rvalid=0.
REQ-032 Same-edge we/re at address 7 with wdata=0x3C, old value 0x11 -> rdata=0x3C; a later read of address 7 -> 0x3C.
REQ-033 Fill all 16 words with 0xFF, then pulse clr_req -> busy high for exactly 16 cycles; we/re during busy ignored (rvalid=0); reads afterwards return 0x00 everywhere.
REQ-034 clr_req with we=1, waddr=0, wdata=0x55, re=1, raddr=2 (mem[2]=0x22) -> rdata=0x22 with rvalid=1; sweep starts; mem[0]=0x00 after the sweep.
REQ-035 rst_n=0 at sweep cycle 5 -> busy=0, state IDLE, all words 0x00 on the next edge; rdata=0, rvalid=0.
REQ-036 Parameter set DATA_W=16, ADDR_W=6: write/read 0xBEEF at address 63 -> correct readback; clear sweep busy for exactly 64 cycles.
